// File: rtl/life_sequencer.sv
// Control sequencer for the Life tile grid: button sync/edge detect, edit cursor, lock strobe, generation scheduling.
// Button actions land 3 clocks after the raw edge; step_req is held until step_ack and never withdrawn early.
module life_sequencer #(
  parameter int GRID_ROWS      = 8,
  parameter int GRID_COLS      = 8,
  parameter int FRAMES_PER_GEN = 100,
  parameter int REPEAT_FRAMES  = 32,
  parameter int GEN_W          = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         frame_end,
  input  logic                         btn_next,
  input  logic                         btn_lock,
  input  logic                         btn_run,
  input  logic                         btn_edit,
  input  logic                         btn_step,
  input  logic                         step_ack,
  output logic                         run_mode,
  output logic [$clog2(GRID_ROWS)-1:0] focus_row,
  output logic [$clog2(GRID_COLS)-1:0] focus_col,
  output logic                         lock_pulse,
  output logic                         step_req,
  output logic [GEN_W-1:0]             gen_count
);

  localparam int RW  = $clog2(GRID_ROWS);
  localparam int CW  = $clog2(GRID_COLS);
  localparam int FW  = $clog2(FRAMES_PER_GEN + 1);
  localparam int RPW = $clog2(REPEAT_FRAMES + 1);

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    RUN  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           ret, ret_nxt;
  logic           pending_edit, pending_edit_nxt;
  logic [FW-1:0]  frame_cnt, frame_cnt_nxt;
  logic [RPW-1:0] rpt_cnt;

  logic [4:0] btn_raw, sync1, sync2, sync_prev, edge_ev;
  logic       next_ev, lock_ev, run_ev, edit_ev, step_ev, rpt_fire;

  logic [RW-1:0]    row_nxt;
  logic [CW-1:0]    col_nxt;
  logic             lock_nxt;
  logic [GEN_W-1:0] gen_nxt;

  assign btn_raw = {btn_step, btn_edit, btn_run, btn_lock, btn_next};
  assign edge_ev = sync2 & ~sync_prev;

  // Holding btn_next re-fires once every REPEAT_FRAMES frames; release restarts the count.
  assign rpt_fire = sync2[0] & frame_end & (rpt_cnt == RPW'(REPEAT_FRAMES - 1));

  assign next_ev = edge_ev[0] | rpt_fire;
  assign lock_ev = edge_ev[1];
  assign run_ev  = edge_ev[2];
  assign edit_ev = edge_ev[3];
  assign step_ev = edge_ev[4];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      rpt_cnt   <= '0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (!sync2[0])
        rpt_cnt <= '0;
      else if (frame_end)
        rpt_cnt <= rpt_fire ? '0 : rpt_cnt + RPW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= EDIT;
      ret          <= 1'b0;
      pending_edit <= 1'b0;
      frame_cnt    <= '0;
      focus_row    <= '0;
      focus_col    <= '0;
      lock_pulse   <= 1'b0;
      gen_count    <= '0;
    end else begin
      state        <= state_nxt;
      ret          <= ret_nxt;
      pending_edit <= pending_edit_nxt;
      frame_cnt    <= frame_cnt_nxt;
      focus_row    <= row_nxt;
      focus_col    <= col_nxt;
      lock_pulse   <= lock_nxt;
      gen_count    <= gen_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    ret_nxt          = ret;
    pending_edit_nxt = pending_edit;
    frame_cnt_nxt    = frame_cnt;
    row_nxt          = focus_row;
    col_nxt          = focus_col;
    lock_nxt         = 1'b0;
    gen_nxt          = gen_count;
    case (state)
      EDIT: begin
        // Only the highest-priority event acts; the rest are dropped.
        if (run_ev) begin
          state_nxt     = RUN;
          frame_cnt_nxt = '0;
        end else if (step_ev) begin
          state_nxt = REQ;
          ret_nxt   = 1'b0;
        end else if (lock_ev) begin
          lock_nxt = 1'b1;
        end else if (next_ev) begin
          if (focus_col == CW'(GRID_COLS - 1)) begin
            col_nxt = '0;
            row_nxt = (focus_row == RW'(GRID_ROWS - 1)) ? '0 : focus_row + RW'(1);
          end else begin
            col_nxt = focus_col + CW'(1);
          end
        end
      end
      RUN: begin
        if (edit_ev) begin
          state_nxt = EDIT;
        end else if (frame_end) begin
          if (frame_cnt == FW'(FRAMES_PER_GEN - 1)) begin
            state_nxt     = REQ;
            ret_nxt       = 1'b1;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + FW'(1);
          end
        end
      end
      REQ: begin
        // Leaving REQ forces at least one low cycle on step_req before the next request.
        if (step_ack) begin
          gen_nxt          = gen_count + GEN_W'(1);
          pending_edit_nxt = 1'b0;
          state_nxt        = (pending_edit || edit_ev || !ret) ? EDIT : RUN;
        end else if (edit_ev) begin
          pending_edit_nxt = 1'b1;
        end
      end
      default: state_nxt = EDIT;
    endcase
  end

  assign step_req = (state == REQ);
  assign run_mode = (state == RUN) || ((state == REQ) && ret);

endmodule
